// File: rtl/epu_axi_slave_bridge_if.sv
// AXI4 slave-side bus bundle (AR/R/AW/W/B channels) between the interconnect and the EPU buffer bridge.
interface epu_axi_slave_bridge_if #(
  parameter int IDW = 8,
  parameter int AW  = 32,
  parameter int DW  = 32
);
  logic [IDW-1:0] ARID;
  logic [AW-1:0]  ARADDR;
  logic [3:0]     ARLEN;
  logic [2:0]     ARSIZE;
  logic [1:0]     ARBURST;
  logic           ARVALID;
  logic           ARREADY;

  logic [IDW-1:0] RID;
  logic [DW-1:0]  RDATA;
  logic [1:0]     RRESP;
  logic           RLAST;
  logic           RVALID;
  logic           RREADY;

  logic [IDW-1:0] AWID;
  logic [AW-1:0]  AWADDR;
  logic [3:0]     AWLEN;
  logic [2:0]     AWSIZE;
  logic [1:0]     AWBURST;
  logic           AWVALID;
  logic           AWREADY;

  logic [DW-1:0]  WDATA;
  logic [3:0]     WSTRB;
  logic           WLAST;
  logic           WVALID;
  logic           WREADY;

  logic [IDW-1:0] BID;
  logic [1:0]     BRESP;
  logic           BVALID;
  logic           BREADY;

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY,
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY,
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );
endinterface

// File: rtl/epu_axi_slave_bridge.sv
// AXI4 slave -> EPU input buffer sequencer: each read beat is an address cycle plus a data cycle (first RVALID 2 cycles after AR),
// write beats stream once WDATA is reached; R/B wait on RREADY/BREADY, new bursts are refused while the EPU owns the buffer.
module epu_axi_slave_bridge #(
  parameter int IDW       = 8,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int BUF_BYTES = 262144
) (
  input  logic                   clk,
  input  logic                   rst,
  epu_axi_slave_bridge_if.slave  s_axi,
  input  logic                   epu_busy_i,
  output logic                   arhns_o,
  output logic                   awhns_o,
  output logic                   rhns_o,
  output logic                   whns_o,
  output logic                   rdfin_o,
  output logic                   wrfin_o,
  output logic                   cs_o,
  output logic                   oe_o,
  output logic [AW-1:0]          addr_o,
  output logic [DW-1:0]          wdata_o,
  input  logic [DW-1:0]          rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_RADDR, S_RDATA, S_WADDR, S_WDATA, S_WRESP
  } state_t;

  state_t         r_state;
  logic [IDW-1:0] r_id;
  logic [AW-1:0]  r_addr;
  logic [3:0]     r_len;
  logic [1:0]     r_burst;
  logic [3:0]     r_beat;
  logic           r_err;

  logic           w_idle_ok;
  logic           w_ar_hs;
  logic           w_aw_hs;
  logic           w_r_hs;
  logic           w_w_hs;
  logic           w_last_beat;
  logic           w_oor;
  logic [AW-1:0]  w_step;
  logic           w_unused;

  // Reads take priority over writes when both address channels are valid.
  assign w_idle_ok   = (r_state == S_IDLE) && !epu_busy_i && !rst;
  assign w_ar_hs     = w_idle_ok && s_axi.ARVALID;
  assign w_aw_hs     = w_idle_ok && !s_axi.ARVALID && s_axi.AWVALID;
  assign w_r_hs      = (r_state == S_RDATA) && s_axi.RREADY;
  assign w_w_hs      = (r_state == S_WDATA) && s_axi.WVALID;
  assign w_last_beat = (r_beat == r_len);
  assign w_oor       = (r_addr >= AW'(BUF_BYTES));
  assign w_step      = (r_burst == 2'b00) ? '0 : AW'(4);
  assign w_unused    = ^{s_axi.ARSIZE, s_axi.AWSIZE, s_axi.WSTRB};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_burst <= '0;
      r_beat  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ar_hs) begin
            r_id    <= s_axi.ARID;
            r_addr  <= s_axi.ARADDR;
            r_len   <= s_axi.ARLEN;
            r_burst <= s_axi.ARBURST;
            r_beat  <= '0;
            r_state <= S_RADDR;
          end else if (w_aw_hs) begin
            r_id    <= s_axi.AWID;
            r_addr  <= s_axi.AWADDR;
            r_len   <= s_axi.AWLEN;
            r_burst <= s_axi.AWBURST;
            r_beat  <= '0;
            r_err   <= 1'b0;
            r_state <= S_WADDR;
          end
        end
        S_RADDR: r_state <= S_RDATA;
        S_RDATA: begin
          if (w_r_hs) begin
            if (w_last_beat) begin
              r_state <= S_IDLE;
            end else begin
              r_beat  <= r_beat + 4'd1;
              r_addr  <= r_addr + w_step;
              r_state <= S_RADDR;
            end
          end
        end
        S_WADDR: r_state <= S_WDATA;
        S_WDATA: begin
          if (w_w_hs) begin
            r_beat <= r_beat + 4'd1;
            r_addr <= r_addr + w_step;
            // Sticky: any dropped beat or WLAST/LEN disagreement poisons the B response.
            if (w_oor || (s_axi.WLAST != w_last_beat)) r_err <= 1'b1;
            if (s_axi.WLAST || w_last_beat) r_state <= S_WRESP;
          end
        end
        S_WRESP: if (s_axi.BREADY) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_axi.ARREADY = w_idle_ok;
  assign s_axi.AWREADY = w_idle_ok && !s_axi.ARVALID;
  assign s_axi.RVALID  = (r_state == S_RDATA);
  assign s_axi.RID     = r_id;
  assign s_axi.RLAST   = (r_state == S_RDATA) && w_last_beat;
  assign s_axi.RRESP   = ((r_state == S_RDATA) && w_oor) ? 2'b10 : 2'b00;
  assign s_axi.RDATA   = ((r_state == S_RDATA) && !w_oor) ? rdata_i : '0;
  assign s_axi.WREADY  = (r_state == S_WDATA);
  assign s_axi.BVALID  = (r_state == S_WRESP);
  assign s_axi.BID     = r_id;
  assign s_axi.BRESP   = ((r_state == S_WRESP) && r_err) ? 2'b10 : 2'b00;

  assign arhns_o = w_ar_hs;
  assign awhns_o = w_aw_hs;
  assign rhns_o  = w_r_hs;
  assign rdfin_o = w_r_hs && w_last_beat;
  assign whns_o  = w_w_hs && !w_oor;
  assign wrfin_o = w_w_hs && (s_axi.WLAST || w_last_beat);
  assign cs_o    = (r_state == S_RADDR) || (r_state == S_RDATA) ||
                   (r_state == S_WADDR) || (r_state == S_WDATA);
  assign oe_o    = (r_state == S_RADDR) || (r_state == S_RDATA);
  assign addr_o  = r_addr;
  assign wdata_o = s_axi.WDATA;

endmodule

// File: tb/tb_epu_axi_slave_bridge.sv
// Directed bench for epu_axi_slave_bridge: hand-computed expectations checked with immediate assertions.
module tb_epu_axi_slave_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        epu_busy_i;
  logic        arhns_o, awhns_o, rhns_o, whns_o, rdfin_o, wrfin_o;
  logic        cs_o, oe_o;
  logic [31:0] addr_o, wdata_o, rdata_i;

  int n_tests = 0;
  int n_fail  = 0;

  epu_axi_slave_bridge_if #(.IDW(8), .AW(32), .DW(32)) axi ();

  epu_axi_slave_bridge #(.IDW(8), .AW(32), .DW(32), .BUF_BYTES(262144)) dut (
    .clk(clk), .rst(rst), .s_axi(axi.slave), .epu_busy_i(epu_busy_i),
    .arhns_o(arhns_o), .awhns_o(awhns_o), .rhns_o(rhns_o), .whns_o(whns_o),
    .rdfin_o(rdfin_o), .wrfin_o(wrfin_o), .cs_o(cs_o), .oe_o(oe_o),
    .addr_o(addr_o), .wdata_o(wdata_o), .rdata_i(rdata_i)
  );

  always #5 clk = ~clk;

  // Buffer contents: one marker word, everything else derived from the address.
  function automatic logic [31:0] bufword(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (32'hC0DE0000 | {16'h0, a[15:0]});
  endfunction
  assign rdata_i = bufword(addr_o);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; epu_busy_i = 1'b0;
    axi.ARID = '0; axi.ARADDR = '0; axi.ARLEN = '0; axi.ARSIZE = 3'd2; axi.ARBURST = 2'b01; axi.ARVALID = 1'b0;
    axi.RREADY = 1'b0;
    axi.AWID = '0; axi.AWADDR = '0; axi.AWLEN = '0; axi.AWSIZE = 3'd2; axi.AWBURST = 2'b01; axi.AWVALID = 1'b0;
    axi.WDATA = '0; axi.WSTRB = 4'hF; axi.WLAST = 1'b0; axi.WVALID = 1'b0; axi.BREADY = 1'b0;

    // Reset state
    nxt(); nxt(); settle();
    chk("rst_arready", axi.ARREADY, 0);
    chk("rst_awready", axi.AWREADY, 0);
    chk("rst_rvalid",  axi.RVALID, 0);
    chk("rst_wready",  axi.WREADY, 0);
    chk("rst_bvalid",  axi.BVALID, 0);
    chk("rst_addr",    addr_o, 0);
    chk("rst_cs",      cs_o, 0);
    chk("rst_rid",     axi.RID, 0);

    // Single read at 0x10
    nxt(); rst = 1'b0;
    axi.ARVALID = 1'b1; axi.ARADDR = 32'h10; axi.ARLEN = 4'd0; axi.ARID = 8'h03; axi.RREADY = 1'b1;
    settle();
    chk("rd1_arready", axi.ARREADY, 1);
    chk("rd1_arhns",   arhns_o, 1);
    nxt(); axi.ARVALID = 1'b0; settle();
    chk("rd1_raddr_cs_oe", {cs_o, oe_o}, 2'b11);
    chk("rd1_raddr_addr",  addr_o, 32'h10);
    chk("rd1_raddr_rvalid", axi.RVALID, 0);
    nxt(); settle();
    chk("rd1_rvalid", axi.RVALID, 1);
    chk("rd1_rdata",  axi.RDATA, 32'hDEADBEEF);
    chk("rd1_rlast_rresp_rid", {axi.RLAST, axi.RRESP, axi.RID}, {1'b1, 2'b00, 8'h03});
    chk("rd1_rhns_rdfin", {rhns_o, rdfin_o}, 2'b11);
    nxt(); settle();
    chk("rd1_idle_rvalid", axi.RVALID, 0);

    // 4-beat INCR write from 0x100
    axi.AWVALID = 1'b1; axi.AWADDR = 32'h100; axi.AWLEN = 4'd3; axi.AWID = 8'h05; axi.AWBURST = 2'b01;
    settle();
    chk("wr4_awready", axi.AWREADY, 1);
    chk("wr4_awhns",   awhns_o, 1);
    nxt(); axi.AWVALID = 1'b0; axi.WVALID = 1'b1; axi.WDATA = 32'd1; axi.WLAST = 1'b0; settle();
    chk("wr4_waddr_awhns", awhns_o, 0);
    chk("wr4_waddr_wready", axi.WREADY, 0);
    chk("wr4_waddr_cs_oe", {cs_o, oe_o}, 2'b10);
    chk("wr4_waddr_whns", whns_o, 0);
    for (int i = 0; i < 4; i++) begin
      nxt(); axi.WDATA = 32'(i + 1); axi.WLAST = (i == 3); settle();
      chk("wr4_wready", axi.WREADY, 1);
      chk("wr4_whns",   whns_o, 1);
      chk("wr4_addr",   addr_o, 32'h100 + 32'(4 * i));
      chk("wr4_wdata",  wdata_o, 32'(i + 1));
      chk("wr4_wrfin",  wrfin_o, (i == 3));
    end
    nxt(); axi.WVALID = 1'b0; axi.WLAST = 1'b0; axi.BREADY = 1'b0; settle();
    chk("wr4_bvalid", axi.BVALID, 1);
    chk("wr4_bresp_bid", {axi.BRESP, axi.BID}, {2'b00, 8'h05});
    nxt(); axi.BREADY = 1'b1; settle();
    chk("wr4_bvalid_hold", axi.BVALID, 1);
    nxt(); axi.BREADY = 1'b0; settle();
    chk("wr4_idle_bvalid", axi.BVALID, 0);

    // Read backpressure: 2 beats at 0x200, RREADY low 3 cycles on beat 0
    axi.ARVALID = 1'b1; axi.ARADDR = 32'h200; axi.ARLEN = 4'd1; axi.ARID = 8'h07; axi.RREADY = 1'b0;
    settle();
    chk("bp_arhns", arhns_o, 1);
    nxt(); axi.ARVALID = 1'b0;
    nxt(); settle();
    for (int k = 0; k < 3; k++) begin
      chk("bp_stall_rvalid", axi.RVALID, 1);
      chk("bp_stall_rdata",  axi.RDATA, bufword(32'h200));
      chk("bp_stall_addr",   addr_o, 32'h200);
      chk("bp_stall_rhns_rlast", {rhns_o, axi.RLAST}, 2'b00);
      nxt(); settle();
    end
    axi.RREADY = 1'b1; settle();
    chk("bp_b0_rhns_rdfin", {rhns_o, rdfin_o}, 2'b10);
    chk("bp_b0_rlast", axi.RLAST, 0);
    nxt(); axi.RREADY = 1'b0; settle();
    chk("bp_raddr1_rvalid", axi.RVALID, 0);
    chk("bp_raddr1_addr", addr_o, 32'h204);
    chk("bp_raddr1_rhns", rhns_o, 0);
    nxt(); axi.RREADY = 1'b1; settle();
    chk("bp_b1_rdata", axi.RDATA, bufword(32'h204));
    chk("bp_b1_rlast_rdfin", {axi.RLAST, rdfin_o}, 2'b11);
    nxt(); axi.RREADY = 1'b0;

    // Simultaneous AR and AW: read first, write after
    axi.ARVALID = 1'b1; axi.ARADDR = 32'h10; axi.ARLEN = 4'd0; axi.ARID = 8'h01; axi.RREADY = 1'b1;
    axi.AWVALID = 1'b1; axi.AWADDR = 32'h300; axi.AWLEN = 4'd0; axi.AWID = 8'h09;
    settle();
    chk("arb_ready", {axi.ARREADY, axi.AWREADY}, 2'b10);
    chk("arb_hns",   {arhns_o, awhns_o}, 2'b10);
    nxt(); axi.ARVALID = 1'b0; settle();
    chk("arb_raddr_awready", axi.AWREADY, 0);
    nxt(); settle();
    chk("arb_rdata_awready", axi.AWREADY, 0);
    chk("arb_rdfin", rdfin_o, 1);
    nxt(); settle();
    chk("arb_aw_accept", {axi.AWREADY, awhns_o}, 2'b11);
    nxt(); axi.AWVALID = 1'b0; axi.WVALID = 1'b1; axi.WDATA = 32'hAA; axi.WLAST = 1'b1;
    nxt(); settle();
    chk("arb_w_hns_fin", {whns_o, wrfin_o}, 2'b11);
    chk("arb_w_addr", addr_o, 32'h300);
    nxt(); axi.WVALID = 1'b0; axi.WLAST = 1'b0; axi.BREADY = 1'b1; settle();
    chk("arb_b", {axi.BVALID, axi.BRESP, axi.BID}, {1'b1, 2'b00, 8'h09});
    nxt(); axi.BREADY = 1'b0;

    // EPU busy blocks AR acceptance
    epu_busy_i = 1'b1; axi.ARVALID = 1'b1; axi.ARADDR = 32'h20; axi.ARLEN = 4'd0; axi.ARID = 8'h04;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("busy_blocked", {axi.ARREADY, arhns_o}, 2'b00);
      nxt();
    end
    epu_busy_i = 1'b0; settle();
    chk("busy_release", {axi.ARREADY, arhns_o}, 2'b11);
    nxt(); axi.ARVALID = 1'b0;
    nxt(); settle();
    chk("busy_rdata", axi.RDATA, bufword(32'h20));
    chk("busy_rid", axi.RID, 8'h04);
    nxt();

    // Out-of-range write at BUF_BYTES
    axi.AWVALID = 1'b1; axi.AWADDR = 32'h40000; axi.AWLEN = 4'd0; axi.AWID = 8'h02;
    settle();
    chk("oor_w_awhns", awhns_o, 1);
    nxt(); axi.AWVALID = 1'b0; axi.WVALID = 1'b1; axi.WDATA = 32'h55; axi.WLAST = 1'b1;
    nxt(); settle();
    chk("oor_w_whns_wrfin", {whns_o, wrfin_o}, 2'b01);
    nxt(); axi.WVALID = 1'b0; axi.WLAST = 1'b0; axi.BREADY = 1'b1; settle();
    chk("oor_w_bresp", {axi.BVALID, axi.BRESP}, {1'b1, 2'b10});
    nxt(); axi.BREADY = 1'b0;

    // Read straddling the end of the buffer
    axi.ARVALID = 1'b1; axi.ARADDR = 32'h3FFFC; axi.ARLEN = 4'd1; axi.ARID = 8'h06; axi.RREADY = 1'b1;
    nxt(); axi.ARVALID = 1'b0;
    nxt(); settle();
    chk("oor_r_b0", {axi.RRESP, axi.RLAST}, {2'b00, 1'b0});
    chk("oor_r_b0_data", axi.RDATA, 32'hC0DEFFFC);
    nxt();
    nxt(); settle();
    chk("oor_r_b1", {axi.RRESP, axi.RLAST}, {2'b10, 1'b1});
    chk("oor_r_b1_data", axi.RDATA, 32'h0);
    chk("oor_r_b1_addr", addr_o, 32'h40000);
    nxt();

    // Reset mid-burst aborts without a response
    axi.ARVALID = 1'b1; axi.ARADDR = 32'h80; axi.ARLEN = 4'd3; axi.ARID = 8'h0A; axi.RREADY = 1'b0;
    nxt(); axi.ARVALID = 1'b0;
    nxt(); settle();
    chk("mid_rvalid_before", axi.RVALID, 1);
    rst = 1'b1;
    nxt(); settle();
    chk("mid_rst_outputs", {axi.RVALID, cs_o, oe_o, axi.ARREADY}, 4'b0000);
    chk("mid_rst_addr_rid", {addr_o, axi.RID}, 40'h0);
    rst = 1'b0;
    nxt(); settle();
    chk("mid_idle_rvalid", {axi.RVALID, axi.ARREADY}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
